// File: rtl/coi_pkg.sv
// Shared types and constants for the cascade-of-integrators decimation filter.
// The optional dump feature (COI_DUMP_EN) is handled in coi_dec_filter.
package coi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } coi_state_e;

  localparam int ORDER_MAX = 4;

  // Stage i of an all-ones conversion reaches C(N,i), which fits in ORDER*NW bits.
  function automatic int coi_min_ow(input int order, input int nw);
    return order * nw;
  endfunction

endpackage

// File: rtl/coi_integ_stage.sv
// One integrator of the cascade: an OW-bit accumulator with a synchronous clear
// and an enable. Clear wins over enable.
module coi_integ_stage #(
  parameter int OW = 22
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [OW-1:0] add_i,
  output logic [OW-1:0] acc_o
);

  logic [OW-1:0] acc_q;
  logic [OW-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + add_i;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/coi_dec_filter.sv
// Parametrised CoI decimation filter for incremental delta-sigma ADCs.
// Optional macro COI_DUMP_EN adds a 'dump' input that ends a conversion early.
module coi_dec_filter
  import coi_pkg::*;
#(
  parameter int ORDER = 2,
  parameter int NW    = 11,
  parameter int OW    = coi_min_ow(ORDER, NW)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic [NW-1:0] N_in,
  input  logic [1:0]    ord_sel,
  input  logic          d_in,
`ifdef COI_DUMP_EN
  input  logic          dump,
`endif
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] d_out
);

  if (ORDER < 1 || ORDER > ORDER_MAX || OW < coi_min_ow(ORDER, NW)) begin : g_bad_cfg
    $error("coi_dec_filter: illegal ORDER/NW/OW combination");
  end

  localparam logic [1:0] SEL_MAX = 2'(ORDER - 1);

  coi_state_e    state_q;
  logic [NW-1:0] n_q;
  logic [NW-1:0] count_q;
  logic [1:0]    sel_q;
  logic          busy_q;
  logic          done_q;

  logic          run_en;
  logic          start_acc;
  logic          dump_hit;
  logic          end_run;
  logic [1:0]    sel_clamp;

  assign run_en    = (state_q == RUN);
  assign start_acc = start && (state_q != RUN);
  assign sel_clamp = (ord_sel > SEL_MAX) ? SEL_MAX : ord_sel;

`ifdef COI_DUMP_EN
  assign dump_hit = run_en && dump;
`else
  assign dump_hit = 1'b0;
`endif

  // The sample at the terminal (or dump) edge is still integrated by the stages.
  assign end_run = run_en && (dump_hit || (count_q == (n_q - NW'(1))));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      n_q     <= '0;
      count_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            count_q <= '0;
            n_q     <= N_in;
            sel_q   <= sel_clamp;
            if (N_in == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          count_q <= count_q + NW'(1);
          if (end_run) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [OW-1:0] stage_in [ORDER];
  logic [OW-1:0] stage_q  [ORDER];

  for (genvar g = 0; g < ORDER; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign stage_in[g] = {{(OW-1){1'b0}}, d_in};
    end else begin : g_next
      assign stage_in[g] = stage_q[g-1];
    end

    coi_integ_stage #(.OW(OW)) u_stage (
      .clk   (clk),
      .rstb  (rstb),
      .clr_i (start_acc),
      .en_i  (run_en),
      .add_i (stage_in[g]),
      .acc_o (stage_q[g])
    );
  end

  logic [OW-1:0] dout_sel;

  always_comb begin
    dout_sel = '0;
    for (int i = 0; i < ORDER; i++) begin
      if (sel_q == 2'(i)) begin
        dout_sel = stage_q[i];
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d_out = done_q ? dout_sel : '0;

endmodule

// File: tb/tb_coi_dec_filter.sv
// Directed self-checking bench for coi_dec_filter (ORDER=2 and ORDER=3 instances).
// Expected results come from a cascade model and are queued per conversion.
module tb_coi_dec_filter;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start2, start3;
  logic [10:0] N_in;
  logic [1:0]  ord_sel;
  logic        d_in;
  logic        busy2, done2, busy3, done3;
  logic [21:0] dout2;
  logic [32:0] dout3;
`ifdef COI_DUMP_EN
  logic        dump2, dump3;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  coi_dec_filter #(.ORDER(2), .NW(11)) u_dut2 (
    .clk     (clk),
    .rstb    (rstb),
    .start   (start2),
    .N_in    (N_in),
    .ord_sel (ord_sel),
    .d_in    (d_in),
`ifdef COI_DUMP_EN
    .dump    (dump2),
`endif
    .busy    (busy2),
    .done    (done2),
    .d_out   (dout2)
  );

  coi_dec_filter #(.ORDER(3), .NW(11)) u_dut3 (
    .clk     (clk),
    .rstb    (rstb),
    .start   (start3),
    .N_in    (N_in),
    .ord_sel (ord_sel),
    .d_in    (d_in),
`ifdef COI_DUMP_EN
    .dump    (dump3),
`endif
    .busy    (busy3),
    .done    (done3),
    .d_out   (dout3)
  );

  function automatic logic [63:0] obs_dout(input int dut);
    return (dut == 3) ? 64'(dout3) : 64'(dout2);
  endfunction

  function automatic logic [63:0] obs_busy(input int dut);
    return (dut == 3) ? 64'(busy3) : 64'(busy2);
  endfunction

  function automatic logic [63:0] obs_done(input int dut);
    return (dut == 3) ? 64'(done3) : 64'(done2);
  endfunction

  task automatic set_start(input int dut, input logic v);
    if (dut == 3) start3 = v;
    else          start2 = v;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // pat: 0 all ones, 1 alternating with 1 on the start cycle, 2 random.
  // poke: raise start with different N_in/ord_sel mid-conversion.
  task automatic conv(input int dut, input int n, input int sel, input int pat, input bit poke);
    logic [63:0] m[4];
    logic        smp[$];
    logic [63:0] exp_v;
    int          ord, sel_c, busy_cnt;
    ord = (dut == 3) ? 3 : 2;
    for (int i = 0; i < 4; i++) m[i] = '0;
    for (int j = 1; j <= n; j++) begin
      logic b;
      if (pat == 0)      b = 1'b1;
      else if (pat == 1) b = ((j % 2) == 0);
      else               b = 1'($urandom_range(0, 1));
      smp.push_back(b);
      for (int i = ord - 1; i >= 1; i--) m[i] = m[i] + m[i-1];
      m[0] = m[0] + 64'(b);
    end
    sel_c = (sel > ord - 1) ? ord - 1 : sel;
    sb.push_back(m[sel_c]);

    @(negedge clk);
    N_in    = 11'(n);
    ord_sel = 2'(sel);
    d_in    = 1'b1;
    set_start(dut, 1'b1);
    @(negedge clk);
    set_start(dut, 1'b0);
    check("accept_busy", obs_busy(dut), 64'(n != 0));
    check("accept_done", obs_done(dut), 64'(n == 0));
    busy_cnt = 0;
    for (int j = 0; j < n; j++) begin
      if (obs_busy(dut) == 64'd1) busy_cnt++;
      if (j == n / 2) check("dout_zero_run", obs_dout(dut), 64'd0);
      d_in = smp[j];
      if (poke && j == 1) begin
        set_start(dut, 1'b1);
        N_in    = 11'(n + 2);
        ord_sel = 2'd0;
      end else if (poke && j == 2) begin
        set_start(dut, 1'b0);
      end
      @(negedge clk);
    end
    set_start(dut, 1'b0);
    check("busy_cycles", 64'(busy_cnt), 64'(n));
    check("end_done", obs_done(dut), 64'd1);
    check("end_busy", obs_busy(dut), 64'd0);
    exp_v = sb.pop_front();
    check("result", obs_dout(dut), exp_v);
    d_in = ~d_in;
    @(negedge clk);
    check("result_hold", obs_dout(dut), exp_v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb    = 1'b0;
    start2  = 1'b0;
    start3  = 1'b0;
    N_in    = '0;
    ord_sel = '0;
    d_in    = 1'b0;
`ifdef COI_DUMP_EN
    dump2   = 1'b0;
    dump3   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy2), 64'd0);
    check("rst_done", 64'(done2), 64'd0);
    check("rst_dout", 64'(dout2), 64'd0);
    check("rst_done3", 64'(done3), 64'd0);
    rstb = 1'b1;

    conv(2, 1024, 1, 0, 0);
    check("c1024_2_const", 64'(dout2), 64'd523776);

    for (int s = 0; s < 4; s++) conv(3, 4, s, 0, 0);

    conv(2, 8, 1, 1, 0);
    conv(2, 8, 0, 1, 0);

    conv(2, 3, 1, 0, 1);
    check("c3_2_const", 64'(dout2), 64'd3);

    conv(2, 0, 1, 0, 0);
    conv(2, 13, 1, 2, 0);
    conv(3, 9, 2, 2, 0);

    @(negedge clk);
    N_in    = 11'd20;
    ord_sel = 2'd1;
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    d_in   = 1'b1;
    repeat (5) @(negedge clk);
    rstb = 1'b0;
    #1;
    check("abort_busy", 64'(busy2), 64'd0);
    check("abort_done", 64'(done2), 64'd0);
    check("abort_dout", 64'(dout2), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'(done2), 64'd0);
    conv(2, 5, 1, 0, 0);

`ifdef COI_DUMP_EN
    for (int s = 1; s >= 0; s--) begin
      sb.push_back((s == 1) ? 64'd45 : 64'd10);
      @(negedge clk);
      N_in    = 11'd100;
      ord_sel = 2'(s);
      start2  = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int j = 0; j < 10; j++) begin
        d_in = 1'b1;
        if (j == 9) dump2 = 1'b1;
        @(negedge clk);
      end
      dump2 = 1'b0;
      check("dump_done", 64'(done2), 64'd1);
      check("dump_result", 64'(dout2), sb.pop_front());
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coi_dec_filter.md
Name: coi_dec_filter

Overview:
- Parametrised cascade-of-integrators (CoI) decimation filter for incremental delta-sigma ADCs, successor to the fixed 2nd-order CoI block.
- Accepts a 1-bit modulator stream and integrates over a programmable conversion length.
- Returns the chosen integrator stage with a start/done handshake.
- Supports back-to-back conversions without a global reset; sits between the modulator and the readout/serialiser.

Parameters:
- ORDER, 2, number of cascaded integrator stages (legal 1..4).
- NW, 11, width of conversion-length input and sample counter.
- OW, ORDER*NW, integrator and output width; must be >= ORDER*NW.

Ports:
- clk  in  1  system clock, rising-edge active.
- rstb  in  1  asynchronous active-low reset.
- start  in  1  conversion request, sampled at a rising edge.
- N_in  in  NW  conversion length in samples; latched on accepted start.
- ord_sel  in  2  output stage select, value+1 = stage (0 -> stage 1); latched on accepted start, clamped to ORDER.
- d_in  in  1  modulator bitstream.
- busy  out  1  high while integrating.
- done  out  1  high from conversion end until next accepted start.
- d_out  out  OW  selected stage when done, else 0.

Behaviour:
- Reset (rstb=0, asynchronous): state IDLE, all integrators=0, count=0, busy=0, done=0, d_out=0.
- FSM states:
  - IDLE -> RUN on start=1, or -> DONE on start=1 with N_in=0.
  - RUN -> DONE when the N-th sample is accepted.
  - DONE -> RUN on start=1, or -> DONE on start=1 with N_in=0.
- Accepted start at edge k (state IDLE or DONE):
  - clears all integrators and count;
  - latches N and sel;
  - busy=1 and done=0 after edge k.
- start while RUN: ignored, and N_in/ord_sel changes are not latched.
- RUN edge:
  - s1 <= s1 + d_in (zero-extended);
  - s[i] <= s[i] + s[i-1] using the pre-edge s[i-1] (pipelined cascade);
  - count <= count + 1.
- First sample is d_in at edge k+1; last at edge k+N.
- After edge k+N: busy=0 and done=1. d_out equals s[sel] combinationally from registers and stays stable while in DONE.
- Latency from start to done: N+1 rising edges.
- N_in=0: no integration; done=1 after edge k with d_out=0.
- Arithmetic is modulo 2^OW. No overflow is possible for all-ones input because stage i = C(N,i) < 2^(ORDER*NW).
- d_in is ignored outside RUN.
- Reset asserted mid-conversion aborts immediately with no partial result retained.

Optional Feature:
- Macro: COI_DUMP_EN.
- Defined:
  - adds input port dump (1 bit);
  - dump=1 in RUN at an edge forces a clean early end: the sample at that edge is still integrated, then state goes to DONE with the partial result;
  - dump in IDLE/DONE is ignored; dump has priority over count terminal match (same outcome).
- Undefined: no dump port, and conversions always run exactly N samples.

Decomposition:
- Shared package coi_pkg:
  - FSM state enum (IDLE, RUN, DONE);
  - ORDER_MAX=4 constant;
  - function computing minimum OW from ORDER and NW.
- One sub-module, coi_integ_stage:
  - single OW-bit accumulator with clear and enable;
  - instantiated ORDER times in a generate loop, each fed by the previous stage's registered output (stage 1 fed by d_in).

Test Plan:
- ORDER=2, NW=11, start with N_in=1024, ord_sel=1, d_in=1 constant -> done after 1025 edges, d_out=523776 (C(1024,2)); busy high exactly 1024 cycles.
- ORDER=3, N_in=4, d_in=1: ord_sel=0 -> d_out=4; ord_sel=1 -> 6; ord_sel=2 -> 4 (C(4,3)); ord_sel=3 clamps to stage 3 -> 4.
- ORDER=2, N_in=8, d_in alternating 1,0,... starting 1 -> stage1=4, stage2=12; d_out=0 before done.
- Back-to-back conversions:
  - start pulsed in DONE with N_in=3, d_in=1 -> integrators cleared and done drops the next cycle;
  - new result C(3,2)=3 with no carry-over;
  - start pulsed during RUN -> no effect.
- Conversion with N_in=0 -> done after 1 edge, d_out=0. Then rstb pulsed low mid-RUN -> busy/done/d_out=0 immediately; after release, a new start works.
- COI_DUMP_EN defined, N_in=100, d_in=1, dump at 10th RUN edge -> done, stage1=10, stage2=45.
